// File: rtl/switch_pio_pkg.sv
// switch_pio_pkg: register map and edge-qualification encodings shared by the switch PIO
package switch_pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  typedef enum logic [1:0] {
    EDGE_ANY  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_mode_e;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: per-switch stability counter and accepted (debounced) level
module debounce_bit #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic primed,
  input  logic sample,
  output logic deb
);
  logic [3:0] r_cnt;
  logic       r_deb;
  logic       w_done;
  assign w_done = r_cnt == 4'(STABLE - 1);
  assign deb = r_deb;
  // unprimed tick adopts the sample outright so power-up levels never look like edges
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (tick) begin
      r_cnt <= (primed && sample != r_deb && !w_done) ? r_cnt + 4'd1 : 4'd0;
      r_deb <= (!primed || (sample != r_deb && w_done)) ? sample : r_deb;
    end
endmodule

// File: rtl/switch_debounce_irq.sv
// switch_debounce_irq: Avalon-MM switch PIO with debounce, edge capture and masked level IRQ
module switch_debounce_irq
  import switch_pio_pkg::*;
#(
  parameter int WIDTH     = 18,
  parameter int DIV       = 50000,
  parameter int STABLE    = 4,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_deb_d, r_edge, r_mask;
  logic [WIDTH-1:0] w_deb, w_edge, w_clr, w_rdata;
  logic             r_primed, w_tick, w_wr, w_rd;
  assign w_tick = r_pre == PW'(DIV - 1);
  assign w_wr   = chipselect && !write_n;
  assign w_rd   = chipselect && write_n;
  assign w_clr  = (w_wr && address == ADDR_EDGE) ? writedata : '0;
  assign w_edge = !r_primed                     ? '0 :
                  EDGE_MODE == int'(EDGE_RISE)  ? w_deb & ~r_deb_d :
                  EDGE_MODE == int'(EDGE_FALL)  ? ~w_deb & r_deb_d :
                                                  w_deb ^ r_deb_d;
  assign w_rdata = address == ADDR_DATA ? w_deb :
                   address == ADDR_RAW  ? r_sync2 :
                   address == ADDR_MASK ? r_mask : r_edge;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE(STABLE)) u_bit (
      .clk    (clk),
      .reset  (reset),
      .tick   (w_tick),
      .primed (r_primed),
      .sample (r_sync2[i]),
      .deb    (w_deb[i])
    );
  end
  // deb_d tracks the priming load too, so the first accepted level raises no edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_pre    <= '0;
      r_primed <= 1'b0;
      r_deb_d  <= '0;
      r_edge   <= '0;
      r_mask   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      r_sync1  <= in_port;
      r_sync2  <= r_sync1;
      r_pre    <= w_tick ? '0 : r_pre + PW'(1);
      r_primed <= r_primed | w_tick;
      r_deb_d  <= (w_tick && !r_primed) ? r_sync2 : w_deb;
      r_edge   <= (r_edge & ~w_clr) | w_edge;
      r_mask   <= (w_wr && address == ADDR_MASK) ? writedata : r_mask;
      irq      <= |(r_edge & r_mask);
      readdata <= w_rd ? w_rdata : readdata;
    end
endmodule
